// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns, decode sentinels
// and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [6:0] SEG_BLANK  = 7'h00;
  localparam logic [3:0] NIBBLE_BAD = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } cap_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment to BCD decoder; exact pattern match only.
// Unknown patterns report bad with nibble NIBBLE_BAD.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] segment,
  output logic       blank,
  output logic       bad,
  output logic [3:0] nibble
);

  always_comb begin
    blank  = 1'b0;
    bad    = 1'b0;
    nibble = 4'd0;
    case (segment)
      SEG_0:     nibble = 4'd0;
      SEG_1:     nibble = 4'd1;
      SEG_2:     nibble = 4'd2;
      SEG_3:     nibble = 4'd3;
      SEG_4:     nibble = 4'd4;
      SEG_5:     nibble = 4'd5;
      SEG_6:     nibble = 4'd6;
      SEG_7:     nibble = 4'd7;
      SEG_8:     nibble = 4'd8;
      SEG_9:     nibble = 4'd9;
      SEG_BLANK: blank  = 1'b1;
      default: begin
        bad    = 1'b1;
        nibble = NIBBLE_BAD;
      end
    endcase
  end

endmodule

// File: rtl/segment_capture.sv
// Display-bus readback: samples scanned digits, assembles frames and
// publishes stable values. Colon tracking under SEGMENT_CAPTURE_COLON_EN.
module segment_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int SETTLE        = 2,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT       = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            segment,
  input  logic [DIGITS-1:0]     digit_sel,
  input  logic                  colon_in,
  output logic [4*DIGITS-1:0]   value_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic                  colon_out,
  output logic                  valid,
  output logic                  code_err,
  output logic                  scan_lost
);

`ifdef SEGMENT_CAPTURE_COLON_EN
  localparam logic COLON_EN = 1'b1;
`else
  localparam logic COLON_EN = 1'b0;
`endif

  localparam int IW = $clog2(TIMEOUT + 1);

  logic [DIGITS-1:0]   sel_q, sel_d, cur;
  logic [6:0]          seg_q;
  logic                colon_q;
  cap_state_e          state;
  logic [3:0]          cnt;
  logic [IW-1:0]       idle;
  logic [DIGITS-1:0]   seen, seen_n;
  logic [4*DIGITS-1:0] nib, nib_n, prev_nib;
  logic [DIGITS-1:0]   blk, blk_n, prev_blk;
  logic                fcol, col_n, prev_col;
  logic [2:0]          stable, stable_n;
  logic                dec_blank, dec_bad;
  logic [3:0]          dec_nib;
  logic onehot, change, legal_chg, do_sample;
  logic complete, same_prev, has_bad;
  logic publish, timeout_hit;

  seg7_decode u_dec (
    .segment (seg_q),
    .blank   (dec_blank),
    .bad     (dec_bad),
    .nibble  (dec_nib)
  );

  assign onehot = (sel_q != '0)
    && ((sel_q & (sel_q - DIGITS'(1))) == '0);
  assign change    = sel_q != sel_d;
  assign legal_chg = change && onehot;
  assign do_sample = (state == ST_SAMPLE) && !change;

  always_comb begin
    nib_n   = nib;
    blk_n   = blk;
    col_n   = fcol;
    seen_n  = seen;
    has_bad = 1'b0;
    if (do_sample) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (cur[i]) begin
          nib_n[4*i +: 4] = dec_nib;
          blk_n[i]        = dec_blank;
        end
      end
      if (cur[0]) col_n = colon_q & COLON_EN;
      seen_n = seen | cur;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (nib_n[4*i +: 4] == NIBBLE_BAD) has_bad = 1'b1;
    end
  end

  assign complete  = do_sample && (seen_n == '1);
  assign same_prev = (nib_n == prev_nib)
    && (blk_n == prev_blk) && (col_n == prev_col);

  always_comb begin
    stable_n = 3'd1;
    if (same_prev) begin
      if (stable == 3'(STABLE_FRAMES)) stable_n = stable;
      else stable_n = stable + 3'd1;
    end
  end

  assign publish = complete && !has_bad
    && (stable_n == 3'(STABLE_FRAMES))
    && ((nib_n != value_out) || (blk_n != blank_out)
        || (col_n != colon_out));
  assign timeout_hit = !legal_chg
    && (idle == IW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q     <= '0;
      sel_d     <= '0;
      seg_q     <= '0;
      colon_q   <= 1'b0;
      cur       <= '0;
      state     <= ST_IDLE;
      cnt       <= '0;
      idle      <= '0;
      seen      <= '0;
      nib       <= '0;
      blk       <= '1;
      fcol      <= 1'b0;
      prev_nib  <= '0;
      prev_blk  <= '1;
      prev_col  <= 1'b0;
      stable    <= '0;
      value_out <= '0;
      blank_out <= '1;
      colon_out <= 1'b0;
      valid     <= 1'b0;
      code_err  <= 1'b0;
      scan_lost <= 1'b0;
    end else begin
      sel_q   <= digit_sel;
      sel_d   <= sel_q;
      seg_q   <= segment;
      colon_q <= colon_in;
      valid   <= 1'b0;

      if (change && !onehot) begin
        state <= ST_IDLE;
      end else if (change) begin
        cur <= sel_q;
        cnt <= 4'(SETTLE);
        if (SETTLE == 0) state <= ST_SAMPLE;
        else state <= ST_SETTLE;
      end else begin
        unique case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_SETTLE: begin
            if (cnt <= 4'd1) state <= ST_SAMPLE;
            else cnt <= cnt - 4'd1;
          end
          ST_SAMPLE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end

      if (legal_chg) idle <= '0;
      else if (idle != IW'(TIMEOUT)) idle <= idle + IW'(1);

      nib  <= nib_n;
      blk  <= blk_n;
      fcol <= col_n;
      seen <= seen_n;
      if (do_sample && dec_bad) code_err <= 1'b1;

      // completion wins over a coincident timeout
      if (complete) begin
        prev_nib  <= nib_n;
        prev_blk  <= blk_n;
        prev_col  <= col_n;
        stable    <= stable_n;
        seen      <= '0;
        scan_lost <= 1'b0;
        if (publish) begin
          value_out <= nib_n;
          blank_out <= blk_n;
          colon_out <= col_n;
          valid     <= 1'b1;
        end
      end else if (timeout_hit) begin
        scan_lost <= 1'b1;
        seen      <= '0;
        stable    <= '0;
      end
    end
  end

endmodule
